// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator processor: FETCH/EXEC/MEM/HALT sequencing,
// handshaked data-memory port, carry/zero flags and a general register bank.
module acc_cpu_mc #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 8,
  parameter int unsigned NREG = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [AW+3:0] imem_data,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic          flag_z,
  output logic          flag_c,
  output logic          halted,
  output logic          retire
);

  localparam int unsigned IW  = AW + 4;
  localparam int unsigned RIW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDAC = 4'h1, OP_STAC = 4'h2, OP_MVAC = 4'h3,
    OP_MOVR = 4'h4, OP_JUMP = 4'h5, OP_JMPZ = 4'h6, OP_JPNZ = 4'h7,
    OP_ADD  = 4'h8, OP_SUB  = 4'h9, OP_INAC = 4'hA, OP_CLAC = 4'hB,
    OP_AND  = 4'hC, OP_OR   = 4'hD, OP_XOR  = 4'hE, OP_NOT  = 4'hF
  } op_t;

  state_t        state;
  logic [IW-1:0] ir;
  logic [DW-1:0] regs [NREG];

  op_t           op;
  logic [AW-1:0] t;
  logic [RIW-1:0] ridx;
  logic [DW-1:0] r;

  logic [DW:0]   sum_add;
  logic [DW:0]   sum_sub;
  logic [DW:0]   sum_inc;
  logic [DW-1:0] alu_res;
  logic          alu_c;

  assign op         = op_t'(ir[IW-1:IW-4]);
  assign t          = ir[AW-1:0];
  assign imem_addr  = pc;
  assign dmem_addr  = t;
  assign dmem_wdata = acc;

  // Register index is the low operand bits; a single-register bank always uses entry 0.
  generate
    if (NREG > 1) begin : g_ridx
      assign ridx = t[RIW-1:0];
    end else begin : g_ridx_one
      assign ridx = '0;
    end
  endgenerate

  assign r = regs[ridx];

  // Carry/borrow is bit DW of the widened sum or difference.
  assign sum_add = {1'b0, acc} + {1'b0, r};
  assign sum_sub = {1'b0, acc} - {1'b0, r};
  assign sum_inc = {1'b0, acc} + (DW+1)'(1);

  // Accumulator-result ALU for opcodes 8..F.
  always_comb begin
    alu_res = acc;
    alu_c   = flag_c;
    case (op)
      OP_ADD:  {alu_c, alu_res} = sum_add;
      OP_SUB:  {alu_c, alu_res} = sum_sub;
      OP_INAC: {alu_c, alu_res} = sum_inc;
      OP_CLAC: alu_res = '0;
      OP_AND:  alu_res = acc & r;
      OP_OR:   alu_res = acc | r;
      OP_XOR:  alu_res = acc ^ r;
      OP_NOT:  alu_res = ~acc;
      default: alu_res = acc;
    endcase
  end

  // Control FSM with all architectural state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= '0;
      acc      <= '0;
      ir       <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      halted   <= 1'b0;
      retire   <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs[RIW'(i)] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          ir    <= imem_data;
          pc    <= pc + AW'(1);
          state <= EXEC;
        end
        EXEC: begin
          state  <= FETCH;
          retire <= 1'b1;
          case (op)
            OP_NOP: begin
              if (&t) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end
            OP_LDAC: begin
              dmem_req <= 1'b1;
              dmem_we  <= 1'b0;
              retire   <= 1'b0;
              state    <= MEM;
            end
            OP_STAC: begin
              dmem_req <= 1'b1;
              dmem_we  <= 1'b1;
              retire   <= 1'b0;
              state    <= MEM;
            end
            OP_MVAC: regs[ridx] <= acc;
            OP_MOVR: begin
              acc    <= r;
              flag_z <= (r == '0);
            end
            OP_JUMP: pc <= t;
            OP_JMPZ: if (flag_z) pc <= t;
            OP_JPNZ: if (!flag_z) pc <= t;
            default: begin
              acc    <= alu_res;
              flag_z <= (alu_res == '0);
              if (op == OP_ADD || op == OP_SUB || op == OP_INAC) flag_c <= alu_c;
            end
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            if (!dmem_we) begin
              acc    <= dmem_rdata;
              flag_z <= (dmem_rdata == '0);
            end
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            retire   <= 1'b1;
            state    <= FETCH;
          end
        end
        HALT: begin
          halted   <= 1'b1;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
